// File: rtl/exc_seq_ctrl_pkg.sv
// rtl/exc_seq_ctrl_pkg.sv - shared constants and types for the exception sequencer
// Contents: excode values, exc_type_i bit indices, one-hot event indices,
//           exception vector and the sequencer FSM state enum.
package exc_seq_ctrl_pkg;

    localparam logic [4:0] EXCODE_INT  = 5'd0;
    localparam logic [4:0] EXCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCODE_ADES = 5'd5;
    localparam logic [4:0] EXCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCODE_BP   = 5'd9;
    localparam logic [4:0] EXCODE_RI   = 5'd10;
    localparam logic [4:0] EXCODE_OV   = 5'd12;

    localparam int BIT_ADEL_IF = 31;
    localparam int BIT_RI      = 30;
    localparam int BIT_OV      = 29;
    localparam int BIT_BP      = 28;
    localparam int BIT_SYS     = 27;
    localparam int BIT_ADEL_D  = 26;
    localparam int BIT_ADES    = 25;
    localparam int BIT_ERET    = 0;

    // One-hot event vector, highest index = highest priority.
    localparam int EV_W       = 9;
    localparam int EV_INT     = 8;
    localparam int EV_ADEL_IF = 7;
    localparam int EV_RI      = 6;
    localparam int EV_OV      = 5;
    localparam int EV_BP      = 4;
    localparam int EV_SYS     = 3;
    localparam int EV_ADEL_D  = 2;
    localparam int EV_ADES    = 1;
    localparam int EV_ERET    = 0;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/exc_seq_ctrl_prio_enc.sv
// rtl/exc_seq_ctrl_prio_enc.sv - combinational exception priority encoder
// Ports: exc_type (in, 32) raw exception/eret flags, int_take (in) interrupt taken,
//        ev (out, EV_W) one-hot winning event (all zero if none),
//        excode (out, 5) Cause.ExcCode of the winning event.
module exc_prio_enc
    import exc_seq_ctrl_pkg::*;
(
    input  logic [31:0]     exc_type,
    input  logic            int_take,
    output logic [EV_W-1:0] ev,
    output logic [4:0]      excode
);

    // Bits 24..1 carry no event meaning.
    logic unused_type_bits;
    assign unused_type_bits = ^exc_type[24:1];

    always_comb begin
        ev     = '0;
        excode = EXCODE_INT;
        if (int_take) begin
            ev[EV_INT] = 1'b1;
            excode     = EXCODE_INT;
        end else if (exc_type[BIT_ADEL_IF]) begin
            ev[EV_ADEL_IF] = 1'b1;
            excode         = EXCODE_ADEL;
        end else if (exc_type[BIT_RI]) begin
            ev[EV_RI] = 1'b1;
            excode    = EXCODE_RI;
        end else if (exc_type[BIT_OV]) begin
            ev[EV_OV] = 1'b1;
            excode    = EXCODE_OV;
        end else if (exc_type[BIT_BP]) begin
            ev[EV_BP] = 1'b1;
            excode    = EXCODE_BP;
        end else if (exc_type[BIT_SYS]) begin
            ev[EV_SYS] = 1'b1;
            excode     = EXCODE_SYS;
        end else if (exc_type[BIT_ADEL_D]) begin
            ev[EV_ADEL_D] = 1'b1;
            excode        = EXCODE_ADEL;
        end else if (exc_type[BIT_ADES]) begin
            ev[EV_ADES] = 1'b1;
            excode      = EXCODE_ADES;
        end else if (exc_type[BIT_ERET]) begin
            ev[EV_ERET] = 1'b1;
            excode      = EXCODE_INT;
        end
    end

endmodule

// File: rtl/exc_seq_ctrl.sv
// rtl/exc_seq_ctrl.sv - exception/eret commit sequencer (IDLE -> COMMIT -> FLUSH)
// Inputs : clk, rst (async active-low), exc_valid_i, exc_type_i, exc_pc_i,
//          exc_badaddr_i, exc_in_delayslot_i, int_pending_i, status_exl_i,
//          status_ie_i, epc_i, cp0_wr_ready_i
// Outputs: cp0 bundle (cp0_wr_valid_o, excode_o, epc_o, epc_we_o, bd_o,
//          badvaddr_o, badvaddr_we_o, exl_set_o, exl_clr_o), flush_o,
//          redirect_valid_o, redirect_pc_o, busy_o
// Build option: EXC_SEQ_INT_EN enables interrupt handling; undefined ignores int_pending_i.
module exc_seq_ctrl
    import exc_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_type_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_badaddr_i,
    input  logic        exc_in_delayslot_i,
    input  logic [7:0]  int_pending_i,
    input  logic        status_exl_i,
    input  logic        status_ie_i,
    input  logic [31:0] epc_i,
    output logic        cp0_wr_valid_o,
    input  logic        cp0_wr_ready_i,
    output logic [4:0]  excode_o,
    output logic [31:0] epc_o,
    output logic        epc_we_o,
    output logic        bd_o,
    output logic [31:0] badvaddr_o,
    output logic        badvaddr_we_o,
    output logic        exl_set_o,
    output logic        exl_clr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    state_e state_q, state_d;

    logic int_take;
`ifdef EXC_SEQ_INT_EN
    assign int_take = (|int_pending_i) && status_ie_i && !status_exl_i && exc_valid_i;
`else
    logic unused_int;
    assign unused_int = (^int_pending_i) ^ status_ie_i;
    assign int_take   = 1'b0;
`endif

    logic [EV_W-1:0] ev;
    logic [4:0]      ev_excode;

    exc_prio_enc u_prio_enc (
        .exc_type (exc_type_i),
        .int_take (int_take),
        .ev       (ev),
        .excode   (ev_excode)
    );

    logic accept;
    assign accept = (state_q == ST_IDLE) && exc_valid_i && (|ev);

    // Values captured at acceptance; the commit-stage inputs may change afterwards.
    logic        is_eret;
    logic        epc_we_d;
    logic [31:0] epc_calc;
    assign is_eret  = ev[EV_ERET];
    assign epc_we_d = !is_eret && !status_exl_i;
    assign epc_calc = exc_in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;

    logic [4:0]  excode_q;
    logic [31:0] epc_q, badvaddr_q, redirect_q;
    logic        epc_we_q, bd_q, badvaddr_we_q, exl_set_q, exl_clr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excode_q      <= '0;
            epc_q         <= '0;
            epc_we_q      <= 1'b0;
            bd_q          <= 1'b0;
            badvaddr_q    <= '0;
            badvaddr_we_q <= 1'b0;
            exl_set_q     <= 1'b0;
            exl_clr_q     <= 1'b0;
            redirect_q    <= '0;
        end else if (accept) begin
            excode_q      <= ev_excode;
            epc_we_q      <= epc_we_d;
            epc_q         <= epc_we_d ? epc_calc : 32'd0;
            bd_q          <= epc_we_d && exc_in_delayslot_i;
            badvaddr_we_q <= ev[EV_ADEL_IF] || ev[EV_ADEL_D] || ev[EV_ADES];
            badvaddr_q    <= ev[EV_ADEL_IF] ? exc_pc_i :
                             (ev[EV_ADEL_D] || ev[EV_ADES]) ? exc_badaddr_i : 32'd0;
            exl_set_q     <= !is_eret;
            exl_clr_q     <= is_eret;
            redirect_q    <= is_eret ? epc_i : EXC_VECTOR;
        end
    end

    always_comb begin
        state_d          = state_q;
        cp0_wr_valid_o   = 1'b0;
        excode_o         = '0;
        epc_o            = '0;
        epc_we_o         = 1'b0;
        bd_o             = 1'b0;
        badvaddr_o       = '0;
        badvaddr_we_o    = 1'b0;
        exl_set_o        = 1'b0;
        exl_clr_o        = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy_o         = 1'b1;
                cp0_wr_valid_o = 1'b1;
                excode_o       = excode_q;
                epc_o          = epc_q;
                epc_we_o       = epc_we_q;
                bd_o           = bd_q;
                badvaddr_o     = badvaddr_q;
                badvaddr_we_o  = badvaddr_we_q;
                exl_set_o      = exl_set_q;
                exl_clr_o      = exl_clr_q;
                if (cp0_wr_ready_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy_o           = 1'b1;
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = redirect_q;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// tb/tb_exc_seq_ctrl.sv - directed self-checking bench for exc_seq_ctrl
module tb_exc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [31:0] exc_type_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic [31:0] exc_badaddr_i = '0;
    logic        exc_in_delayslot_i = 1'b0;
    logic [7:0]  int_pending_i = '0;
    logic        status_exl_i = 1'b0;
    logic        status_ie_i = 1'b0;
    logic [31:0] epc_i = '0;
    logic        cp0_wr_ready_i = 1'b1;
    logic        cp0_wr_valid_o;
    logic [4:0]  excode_o;
    logic [31:0] epc_o;
    logic        epc_we_o;
    logic        bd_o;
    logic [31:0] badvaddr_o;
    logic        badvaddr_we_o;
    logic        exl_set_o;
    logic        exl_clr_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [109:0] all_out;
    assign all_out = {cp0_wr_valid_o, excode_o, epc_o, epc_we_o, bd_o, badvaddr_o,
                      badvaddr_we_o, exl_set_o, exl_clr_o, flush_o, redirect_valid_o,
                      redirect_pc_o, busy_o};

    exc_seq_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .exc_valid_i        (exc_valid_i),
        .exc_type_i         (exc_type_i),
        .exc_pc_i           (exc_pc_i),
        .exc_badaddr_i      (exc_badaddr_i),
        .exc_in_delayslot_i (exc_in_delayslot_i),
        .int_pending_i      (int_pending_i),
        .status_exl_i       (status_exl_i),
        .status_ie_i        (status_ie_i),
        .epc_i              (epc_i),
        .cp0_wr_valid_o     (cp0_wr_valid_o),
        .cp0_wr_ready_i     (cp0_wr_ready_i),
        .excode_o           (excode_o),
        .epc_o              (epc_o),
        .epc_we_o           (epc_we_o),
        .bd_o               (bd_o),
        .badvaddr_o         (badvaddr_o),
        .badvaddr_we_o      (badvaddr_we_o),
        .exl_set_o          (exl_set_o),
        .exl_clr_o          (exl_clr_o),
        .flush_o            (flush_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    // Presents one commit-stage event for one cycle; returns at the negedge after acceptance.
    task automatic drive_event(input logic [31:0] t, input logic [31:0] pc, input logic [31:0] ba,
                               input logic ds, input logic exl, input logic [31:0] epc);
        @(negedge clk);
        exc_type_i         = t;
        exc_pc_i           = pc;
        exc_badaddr_i      = ba;
        exc_in_delayslot_i = ds;
        status_exl_i       = exl;
        epc_i              = epc;
        exc_valid_i        = 1'b1;
        @(negedge clk);
        exc_valid_i        = 1'b0;
        exc_type_i         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_release got %h want 0", all_out);
        else pass_cnt++;
    endtask

    task automatic test_ov();
        cp0_wr_ready_i = 1'b1;
        drive_event(32'h2000_0000, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if ({cp0_wr_valid_o, busy_o, flush_o, redirect_valid_o} !== 4'b1100)
            $display("FAIL ov_commit_ctl got %b want 1100", {cp0_wr_valid_o, busy_o, flush_o, redirect_valid_o});
        else pass_cnt++;
        total_cnt++;
        if ({excode_o, epc_o, epc_we_o, bd_o} !== {5'd12, 32'h1000, 1'b1, 1'b0})
            $display("FAIL ov_bundle got %h want %h", {excode_o, epc_o, epc_we_o, bd_o}, {5'd12, 32'h1000, 1'b1, 1'b0});
        else pass_cnt++;
        total_cnt++;
        if ({exl_set_o, exl_clr_o, badvaddr_we_o} !== 3'b100)
            $display("FAIL ov_flags got %b want 100", {exl_set_o, exl_clr_o, badvaddr_we_o});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({cp0_wr_valid_o, busy_o, flush_o, redirect_valid_o, redirect_pc_o} !== {4'b0111, 32'hbfc0_0380})
            $display("FAIL ov_flush got %h want %h", {cp0_wr_valid_o, busy_o, flush_o, redirect_valid_o, redirect_pc_o}, {4'b0111, 32'hbfc0_0380});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (all_out !== '0) $display("FAIL ov_idle got %h want 0", all_out);
        else pass_cnt++;
    endtask

    task automatic test_sys_delayslot();
        drive_event(32'h0800_0000, 32'h2004, 32'h0, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if ({excode_o, epc_o, epc_we_o, bd_o} !== {5'd8, 32'h2000, 1'b1, 1'b1})
            $display("FAIL sys_ds got %h want %h", {excode_o, epc_o, epc_we_o, bd_o}, {5'd8, 32'h2000, 1'b1, 1'b1});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        exc_in_delayslot_i = 1'b0;
    endtask

    task automatic test_stall_priority();
        cp0_wr_ready_i = 1'b0;
        drive_event(32'h6000_0001, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({cp0_wr_valid_o, busy_o, flush_o, excode_o, epc_o} !== {3'b110, 5'd10, 32'h1234})
                $display("FAIL stall_hold_%0d got %h want %h", i, {cp0_wr_valid_o, busy_o, flush_o, excode_o, epc_o}, {3'b110, 5'd10, 32'h1234});
            else pass_cnt++;
            if (i == 1) begin
                exc_valid_i = 1'b1;
                exc_type_i  = 32'h8000_0000;
                exc_pc_i    = 32'h9990;
            end
            if (i == 2) begin
                exc_valid_i = 1'b0;
                exc_type_i  = '0;
            end
            if (i == 3) cp0_wr_ready_i = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if ({busy_o, flush_o, redirect_pc_o} !== {2'b11, 32'hbfc0_0380})
            $display("FAIL stall_flush got %h want %h", {busy_o, flush_o, redirect_pc_o}, {2'b11, 32'hbfc0_0380});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL stall_idle got %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_eret();
        drive_event(32'h0000_0001, 32'h7777, 32'h0, 1'b0, 1'b1, 32'h3000);
        epc_i = 32'hdead_beef;
        total_cnt++;
        if ({exl_clr_o, exl_set_o, epc_we_o, badvaddr_we_o} !== 4'b1000)
            $display("FAIL eret_flags got %b want 1000", {exl_clr_o, exl_set_o, epc_we_o, badvaddr_we_o});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({flush_o, redirect_pc_o} !== {1'b1, 32'h3000})
            $display("FAIL eret_redirect got %h want %h", {flush_o, redirect_pc_o}, {1'b1, 32'h3000});
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ades_exl();
        drive_event(32'h0200_0000, 32'h8000, 32'h5003, 1'b1, 1'b1, 32'h0);
        total_cnt++;
        if ({badvaddr_o, badvaddr_we_o, epc_we_o, bd_o, excode_o, exl_set_o} !== {32'h5003, 3'b100, 5'd5, 1'b1})
            $display("FAIL ades_exl got %h want %h", {badvaddr_o, badvaddr_we_o, epc_we_o, bd_o, excode_o, exl_set_o}, {32'h5003, 3'b100, 5'd5, 1'b1});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        status_exl_i = 1'b0;
        exc_in_delayslot_i = 1'b0;
    endtask

    task automatic test_adel();
        drive_event(32'h8400_0000, 32'h4000, 32'h9999, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if ({excode_o, badvaddr_o, badvaddr_we_o} !== {5'd4, 32'h4000, 1'b1})
            $display("FAIL adel_fetch got %h want %h", {excode_o, badvaddr_o, badvaddr_we_o}, {5'd4, 32'h4000, 1'b1});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        drive_event(32'h0400_0000, 32'h0100, 32'h6001, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if ({excode_o, badvaddr_o, badvaddr_we_o} !== {5'd4, 32'h6001, 1'b1})
            $display("FAIL adel_data got %h want %h", {excode_o, badvaddr_o, badvaddr_we_o}, {5'd4, 32'h6001, 1'b1});
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pc_wrap();
        drive_event(32'h1000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if ({excode_o, epc_o, bd_o} !== {5'd9, 32'hffff_fffc, 1'b1})
            $display("FAIL pc_wrap got %h want %h", {excode_o, epc_o, bd_o}, {5'd9, 32'hffff_fffc, 1'b1});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        exc_in_delayslot_i = 1'b0;
    endtask

    task automatic test_interrupt_option();
        logic int_en;
`ifdef EXC_SEQ_INT_EN
        int_en = 1'b1;
`else
        int_en = 1'b0;
`endif
        int_pending_i = 8'hff;
        status_ie_i   = 1'b1;
        drive_event(32'h0000_0020, 32'h0abc, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (busy_o !== int_en) $display("FAIL int_only_busy got %b want %b", busy_o, int_en);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        drive_event(32'h2000_0000, 32'h0abc, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (excode_o !== (int_en ? 5'd0 : 5'd12))
            $display("FAIL int_vs_ov got %0d want %0d", excode_o, (int_en ? 5'd0 : 5'd12));
        else pass_cnt++;
        repeat (2) @(negedge clk);
        int_pending_i = '0;
        status_ie_i   = 1'b0;
    endtask

    task automatic test_reset_mid_commit();
        cp0_wr_ready_i = 1'b0;
        drive_event(32'h2000_0000, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (cp0_wr_valid_o !== 1'b1) $display("FAIL rstmid_pre got %b want 1", cp0_wr_valid_o);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (all_out !== '0) $display("FAIL rstmid_async got %h want 0", all_out);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        cp0_wr_ready_i = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (all_out !== '0) $display("FAIL rstmid_idle got %h want 0", all_out);
        else pass_cnt++;
        drive_event(32'h0800_0000, 32'h2200, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if ({cp0_wr_valid_o, excode_o} !== {1'b1, 5'd8})
            $display("FAIL rstmid_recover got %h want %h", {cp0_wr_valid_o, excode_o}, {1'b1, 5'd8});
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ov();
        test_sys_delayslot();
        test_stall_priority();
        test_eret();
        test_ades_exl();
        test_adel();
        test_pc_wrap();
        test_interrupt_option();
        test_reset_mid_commit();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/exc_seq_ctrl.md
EXC_SEQ_CTRL -- requirements
Module: exc_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port exc_valid_i, input, 1: commit-stage instruction carries an exception or eret this cycle.
REQ-004 SHALL have port exc_type_i, input, 32, with bit meanings: 31 fetch AdEL, 30 RI, 29 Ov, 28 Bp, 27 Sys, 26 data AdEL, 25 AdES, 0 eret; other bits ignored.
REQ-005 SHALL have port exc_pc_i, input, 32: PC of the commit instruction.
REQ-006 SHALL have port exc_badaddr_i, input, 32: faulting data address.
REQ-007 SHALL have port exc_in_delayslot_i, input, 1: commit instruction is in a delay slot.
REQ-008 SHALL have port int_pending_i, input, 8: Cause.IP AND Status.IM, precomputed by cp0.
REQ-009 SHALL have ports status_exl_i, input, 1, and status_ie_i, input, 1: current Status.EXL and Status.IE.
REQ-010 SHALL have port epc_i, input, 32: current EPC.
REQ-011 SHALL have ports cp0_wr_valid_o, output, 1, and cp0_wr_ready_i, input, 1: valid/ready handshake for the cp0 update bundle.
REQ-012 SHALL have bundle outputs excode_o (5), epc_o (32), epc_we_o (1), bd_o (1), badvaddr_o (32), badvaddr_we_o (1), exl_set_o (1), exl_clr_o (1).
REQ-013 SHALL have outputs flush_o (1), redirect_valid_o (1), redirect_pc_o (32) and busy_o (1).

Function
REQ-014 SHALL implement FSM IDLE -> COMMIT -> FLUSH -> IDLE.
REQ-015 In IDLE, an event SHALL be accepted when exc_valid_i has any of bits 31..25 or 0 set, or when an interrupt is taken; the event and the bundle SHALL be latched, and the next state SHALL be COMMIT.
REQ-016 Event priority SHALL be interrupt > bit31 > 30 > 29 > 28 > 27 > 26 > 25 > eret; exactly one event SHALL be latched.
REQ-017 An interrupt SHALL be taken when int_pending_i != 0, status_ie_i=1, status_exl_i=0 and exc_valid_i=1.
REQ-018 In COMMIT, cp0_wr_valid_o SHALL be 1 and the bundle SHALL be stable until the cycle with cp0_wr_ready_i=1; in the next cycle the FSM SHALL enter FLUSH.
REQ-019 In FLUSH, flush_o and redirect_valid_o SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-020 busy_o SHALL be 1 in COMMIT and FLUSH; exc_valid_i SHALL be ignored while busy_o=1.
REQ-021 For exceptions, redirect_pc_o SHALL be 32'hbfc0_0380 and exl_set_o SHALL be 1.
REQ-022 For exceptions with status_exl_i=0 at acceptance, epc_we_o SHALL be 1; epc_o SHALL be exc_pc_i-4 with bd_o=1 if in a delay slot, else exc_pc_i with bd_o=0.
REQ-023 For exceptions with status_exl_i=1 at acceptance, epc_we_o SHALL be 0 and bd_o SHALL be 0.
REQ-024 excode_o SHALL be Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
REQ-025 badvaddr_we_o SHALL be 1 only for AdEL/AdES; badvaddr_o SHALL be exc_pc_i for bit31 and exc_badaddr_i for bits 26/25.
REQ-026 For eret, redirect_pc_o SHALL be epc_i sampled at acceptance, exl_clr_o SHALL be 1, and exl_set_o, epc_we_o and badvaddr_we_o SHALL be 0.
REQ-027 All PC arithmetic SHALL be 32-bit modulo; exc_pc_i=0 in a delay slot SHALL give epc_o=32'hffff_fffc.

Reset
REQ-028 rst=0 SHALL force IDLE immediately and drive all outputs to 0, from any state including mid-COMMIT; a pending handshake SHALL be dropped.

Configuration
REQ-029 With EXC_SEQ_INT_EN defined, interrupts SHALL be handled as in REQ-017; without it, int_pending_i SHALL be ignored and excode 0 SHALL never be produced.

Structure
REQ-030 A shared package SHALL hold the excode constants, the exc_type_i bit indices, EXC_VECTOR=32'hbfc0_0380 and the FSM state enum.
REQ-031 A sub-module exc_prio_enc SHALL be provided as a combinational priority encoder from (type, interrupt) to one-hot event and excode.

Verification
REQ-032 Ov at pc=0x1000, not in a delay slot, EXL=0, ready=1 -> COMMIT 1 cycle with excode=12, epc=0x1000, bd=0, then a 1-cycle flush with redirect 0xbfc00380.
REQ-033 Sys in a delay slot at pc=0x2004 -> epc=0x2000, bd=1, excode=8.
REQ-034 RI+Ov+eret simultaneously, with ready low for 3 cycles -> excode=10 held stable for 4 cycles of valid, and busy=1 throughout.
REQ-035 eret with epc_i=0x3000 -> exl_clr=1, epc_we=0, redirect=0x3000.
REQ-036 Data AdES with addr=0x5003 while EXL=1 -> badvaddr=0x5003, badvaddr_we=1, epc_we=0.
REQ-037 rst asserted during COMMIT -> all outputs 0 without a clock edge, and IDLE after release.
